// File: rtl/rv32i_pkg.sv
// Purpose: shared constants and packed-port helpers for the RV32I integer register file.
// Latency: n/a (types, constants and combinational functions only).
// Backpressure: n/a.
package rv32i_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ADDR_W   = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Widest packed port vector and widest single field the slicer handles.
  localparam int SLICE_W = 256;
  localparam int FIELD_W = 64;

  // Extract field idx of width w from a packed port vector, zero-filling the upper bits.
  function automatic logic [FIELD_W-1:0] port_slice(input logic [SLICE_W-1:0] vec,
                                                    input int unsigned idx,
                                                    input int unsigned w);
    logic [SLICE_W-1:0] sh;
    logic [FIELD_W-1:0] mask;
    sh   = vec >> (idx * w);
    mask = (w >= FIELD_W) ? {FIELD_W{1'b1}} : ((FIELD_W'(1) << w) - FIELD_W'(1));
    return sh[FIELD_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/reg_bank_sb.sv
// Purpose: per-register pending scoreboard for RAW hazard detection, plus read-port ready flags.
// Latency: pend_vec updates one edge after issue/write; rd_ready is combinational.
// Backpressure: none; issue and writes are accepted every cycle (issue set beats write clear).
module reg_bank_sb
  import rv32i_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_READ = 2,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  input  logic [NUM_REGS-1:0]    wr_hit,
  input  logic [NUM_READ*AW-1:0] rd_addr,
  output logic [NUM_READ-1:0]    rd_ready,
  output logic [NUM_REGS-1:0]    pend_vec
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;
  logic [AW-1:0]       rd_sel;

  // Next pending state: a new producer (issue) supersedes a retiring one (write).
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i == 0) begin
        pend_d[i] = 1'b0;
      end else if (iss_en && (iss_addr == AW'(i))) begin
        pend_d[i] = 1'b1;
      end else if (wr_hit[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  // Scoreboard register; reset discards every in-flight mark.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // A port is ready when its source is not pending, or when the pending value is being bypassed now.
  always_comb begin
    rd_ready = '0;
    rd_sel   = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      rd_sel      = rd_addr[k*AW +: AW];
      rd_ready[k] = (rd_sel == AW'(REG_ZERO)) | ~pend_q[rd_sel] | ((BYPASS != 0) & wr_hit[rd_sel]);
    end
  end

  assign pend_vec = pend_q;

endmodule

// File: rtl/reg_bank_mp.sv
// Purpose: multi-port integer register file with optional write-to-read bypass and pending scoreboard.
// Latency: reads are combinational (zero cycles); writes and issues take effect at the next edge.
// Backpressure: none; consumers gate on rd_ready, writes on the same address resolve to the highest port.
module reg_bank_mp
  import rv32i_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int NUM_REGS  = 32,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 1,
  parameter int BYPASS    = 1,
  // Derived from NUM_REGS; leave at its default.
  parameter int AW        = $clog2(NUM_REGS)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_READ*AW-1:0]   rd_addr,
  output logic [NUM_READ*XLEN-1:0] rd_data,
  output logic [NUM_READ-1:0]      rd_ready,
  input  logic [NUM_WRITE-1:0]     wr_en,
  input  logic [NUM_WRITE*AW-1:0]  wr_addr,
  input  logic [NUM_WRITE*XLEN-1:0] wr_data,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_addr,
  output logic [NUM_REGS-1:0]      pend_vec
);

  // Packed port vectors are widened once so the shared slicer can unpack them.
  logic [SLICE_W-1:0] rd_addr_x;
  logic [SLICE_W-1:0] wr_addr_x;
  logic [SLICE_W-1:0] wr_data_x;

  logic [AW-1:0]   rd_addr_a [NUM_READ];
  logic [AW-1:0]   wr_addr_a [NUM_WRITE];
  logic [XLEN-1:0] wr_data_a [NUM_WRITE];

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic [XLEN-1:0] rd_val;

  assign rd_addr_x = SLICE_W'(rd_addr);
  assign wr_addr_x = SLICE_W'(wr_addr);
  assign wr_data_x = SLICE_W'(wr_data);

  // Unpack per-port address and data fields.
  always_comb begin
    for (int k = 0; k < NUM_READ; k++) begin
      rd_addr_a[k] = AW'(port_slice(rd_addr_x, k, AW));
    end
    for (int j = 0; j < NUM_WRITE; j++) begin
      wr_addr_a[j] = AW'(port_slice(wr_addr_x, j, AW));
      wr_data_a[j] = XLEN'(port_slice(wr_data_x, j, XLEN));
    end
  end

  // One-hot map of registers written this cycle; x0 writes are discarded here.
  always_comb begin
    wr_hit = '0;
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (wr_en[j] && (wr_addr_a[j] != AW'(REG_ZERO))) begin
        wr_hit[wr_addr_a[j]] = 1'b1;
      end
    end
  end

  // Next storage state; later ports overwrite earlier ones so the highest index wins a conflict.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (wr_en[j] && (wr_addr_a[j] != AW'(REG_ZERO))) begin
        regs_d[wr_addr_a[j]] = wr_data_a[j];
      end
    end
  end

  // Storage flops; reset clears every entry and ignores that cycle's writes.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read muxes: x0 forces zero, otherwise bypass from the highest matching write port when enabled.
  always_comb begin
    rd_data = '0;
    rd_val  = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      rd_val = regs_q[rd_addr_a[k]];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WRITE; j++) begin
          if (wr_en[j] && (wr_addr_a[j] == rd_addr_a[k])) begin
            rd_val = wr_data_a[j];
          end
        end
      end
      if (rd_addr_a[k] == AW'(REG_ZERO)) begin
        rd_val = '0;
      end
      rd_data[k*XLEN +: XLEN] = rd_val;
    end
  end

  reg_bank_sb #(
    .NUM_REGS (NUM_REGS),
    .NUM_READ (NUM_READ),
    .BYPASS   (BYPASS),
    .AW       (AW)
  ) u_sb (
    .clock    (clock),
    .reset_n  (reset_n),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_hit   (wr_hit),
    .rd_addr  (rd_addr),
    .rd_ready (rd_ready),
    .pend_vec (pend_vec)
  );

endmodule

// File: tb/tb_reg_bank_mp.sv
// Purpose: bench for reg_bank_mp; bypass and non-bypass instances share one stimulus stream.
// Latency: reads checked before each edge, state checked after it.
// Backpressure: n/a.
module tb_reg_bank_mp;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;

  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_ready_b, rd_ready_n;
  logic [31:0] pend_b, pend_n;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: architectural register contents and pending marks.
  logic [31:0] m_mem [32];
  bit          m_pend [32];

  always #5 clock = ~clock;

  reg_bank_mp #(.XLEN(32), .NUM_REGS(32), .NUM_READ(2), .NUM_WRITE(2), .BYPASS(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_ready(rd_ready_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .pend_vec(pend_b));

  reg_bank_mp #(.XLEN(32), .NUM_REGS(32), .NUM_READ(2), .NUM_WRITE(2), .BYPASS(0)) dut_n (
    .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_ready(rd_ready_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .pend_vec(pend_n));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // True when some write port targets nonzero register a this cycle.
  function automatic bit written(input logic [4:0] a);
    bit w;
    w = 1'b0;
    for (int j = 0; j < 2; j++)
      if (wr_en[j] && wr_addr[j*5 +: 5] == a && a != 5'd0) w = 1'b1;
    return w;
  endfunction

  function automatic logic [31:0] exp_rd(input int k, input bit byp);
    logic [4:0]  a;
    logic [31:0] v;
    a = rd_addr[k*5 +: 5];
    if (a == 5'd0) return 32'h0;
    v = m_mem[a];
    if (byp)
      for (int j = 0; j < 2; j++)
        if (wr_en[j] && wr_addr[j*5 +: 5] == a) v = wr_data[j*32 +: 32];
    return v;
  endfunction

  function automatic logic exp_rdy(input int k, input bit byp);
    logic [4:0] a;
    a = rd_addr[k*5 +: 5];
    if (a == 5'd0) return 1'b1;
    return !m_pend[a] || (byp && written(a));
  endfunction

  function automatic logic [31:0] exp_pend();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // Apply the architectural rules for one clock edge.
  task automatic model_edge();
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = 32'h0;
        m_pend[i] = 1'b0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (iss_en && iss_addr == 5'(i)) m_pend[i] = 1'b1;
        else if (written(5'(i)))        m_pend[i] = 1'b0;
      end
      for (int j = 0; j < 2; j++)
        if (wr_en[j] && wr_addr[j*5 +: 5] != 5'd0) m_mem[wr_addr[j*5 +: 5]] = wr_data[j*32 +: 32];
    end
  endtask

  // Check combinational outputs and scoreboard, then advance one clock.
  task automatic cycle(input bit do_check);
    #1;
    if (do_check) begin
      for (int k = 0; k < 2; k++) begin
        check("rd_byp", 64'(rd_data_b[k*32 +: 32]), 64'(exp_rd(k, 1'b1)));
        check("rd_nob", 64'(rd_data_n[k*32 +: 32]), 64'(exp_rd(k, 1'b0)));
        check("rdy_byp", 64'(rd_ready_b[k]), 64'(exp_rdy(k, 1'b1)));
        check("rdy_nob", 64'(rd_ready_n[k]), 64'(exp_rdy(k, 1'b0)));
      end
      check("pend_byp", 64'(pend_b), 64'(exp_pend()));
      check("pend_nob", 64'(pend_n), 64'(exp_pend()));
    end
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic drive(input logic rst_n, input logic [1:0] we,
                       input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic ie, input logic [4:0] ia,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    reset_n  = rst_n;
    wr_en    = we;
    wr_addr  = {wa1, wa0};
    wr_data  = {wd1, wd0};
    iss_en   = ie;
    iss_addr = ia;
    rd_addr  = {ra1, ra0};
  endtask

  initial begin
    logic [4:0] wa0, wa1, ra0, ra1;
    drive(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle(1'b0);

    // 1: reset clears stored data and scoreboard.
    drive(1'b1, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b1, 5'd6, 5'd5, 5'd6);
    cycle(1'b1);
    drive(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
    cycle(1'b1);
    check("t1_rd_x5", 64'(rd_data_b[31:0]), 64'h0);
    check("t1_pend", 64'(pend_b), 64'h0);

    // 2: x0 ignores writes and issues.
    drive(1'b1, 2'b01, 5'd0, 32'h12345678, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
    cycle(1'b1);
    check("t2_rd_x0", 64'(rd_data_b[31:0]), 64'h0);
    check("t2_pend0", 64'(pend_b[0]), 64'h0);
    check("t2_rdy_x0", 64'(rd_ready_b[0]), 64'h1);

    // 3: same-cycle write/read of x7 with and without bypass.
    drive(1'b1, 2'b01, 5'd7, 32'h11, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
    cycle(1'b1);
    drive(1'b1, 2'b01, 5'd7, 32'h22, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
    #1;
    check("t3_byp_same", 64'(rd_data_b[31:0]), 64'h22);
    check("t3_nob_same", 64'(rd_data_n[31:0]), 64'h11);
    cycle(1'b1);
    drive(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
    #1;
    check("t3_byp_next", 64'(rd_data_b[31:0]), 64'h22);
    check("t3_nob_next", 64'(rd_data_n[31:0]), 64'h22);
    cycle(1'b1);

    // 4: two ports write x9; port 1 wins.
    drive(1'b1, 2'b11, 5'd9, 32'hAAAA, 5'd9, 32'hBBBB, 1'b0, 5'd0, 5'd9, 5'd0);
    cycle(1'b1);
    drive(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
    #1;
    check("t4_conflict", 64'(rd_data_n[31:0]), 64'hBBBB);
    cycle(1'b1);

    // 5: scoreboard set, clear, and set-beats-clear on x3.
    drive(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
    cycle(1'b1);
    check("t5_pend_set", 64'(pend_b[3]), 64'h1);
    check("t5_rdy_lo", 64'(rd_ready_n[0]), 64'h0);
    drive(1'b1, 2'b01, 5'd3, 32'h5, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
    cycle(1'b1);
    drive(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
    #1;
    check("t5_pend_clr", 64'(pend_b[3]), 64'h0);
    check("t5_rdy_hi", 64'(rd_ready_n[0]), 64'h1);
    cycle(1'b1);
    drive(1'b1, 2'b01, 5'd3, 32'h6, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
    cycle(1'b1);
    check("t5_set_wins", 64'(pend_b[3]), 64'h1);

    // 6: reset mid-operation discards pending marks and data.
    drive(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd10, 5'd11);
    cycle(1'b1);
    drive(1'b1, 2'b01, 5'd12, 32'h77, 5'd0, 32'h0, 1'b1, 5'd11, 5'd10, 5'd12);
    cycle(1'b1);
    drive(1'b0, 2'b01, 5'd10, 32'h99, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd12);
    cycle(1'b1);
    check("t6_pend", 64'(pend_b), 64'h0);
    drive(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd12);
    #1;
    check("t6_rd_x10", 64'(rd_data_b[31:0]), 64'h0);
    check("t6_rd_x12", 64'(rd_data_b[63:32]), 64'h0);
    cycle(1'b1);

    // Random traffic with frequent address collisions and occasional resets.
    for (int n = 0; n < 600; n++) begin
      wa0 = 5'($urandom_range(0, 31));
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
      ra0 = ($urandom_range(0, 2) == 0) ? wa0 : 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 2) == 0) ? wa1 : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 49) != 0), 2'($urandom), wa0, $urandom, wa1, $urandom,
            1'($urandom), ($urandom_range(0, 2) == 0) ? wa0 : 5'($urandom_range(0, 31)), ra0, ra1);
      cycle(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_bank_mp.md
Name: reg_bank_mp

Overview:
Parametrised multi-port integer register file for the next-generation RV32I core pipeline. Supersedes the single-write, dual-read bank with:
- N read ports and M write ports.
- Optional same-cycle write-to-read bypass.
- A per-register pending scoreboard used by issue logic to detect RAW hazards.
- Synchronous active-low clear of all state.

Sits between decode/issue (read, scoreboard) and writeback (write ports).

Parameters:
XLEN, 32, data width of each register
NUM_REGS, 32, number of architectural registers (power of two, >= 2); register 0 is hardwired zero
NUM_READ, 2, number of read ports (1..4)
NUM_WRITE, 1, number of write ports (1..2)
BYPASS, 1, 1 = a read of a register being written this cycle returns the write data; 0 = returns the stored (old) value
AW, $clog2(NUM_REGS), derived address width; do not override

Ports:
clock  in  1  system clock, all state updates on rising edge
reset_n  in  1  reset, synchronous active-low (sampled on rising edge of clock)
rd_addr  in  NUM_READ*AW  packed read addresses, port k at [k*AW +: AW]
rd_data  out  NUM_READ*XLEN  packed read data, combinational
rd_ready  out  NUM_READ  1 = port k's register has no pending write
wr_en  in  NUM_WRITE  per-port write enable
wr_addr  in  NUM_WRITE*AW  packed write addresses
wr_data  in  NUM_WRITE*XLEN  packed write data
iss_en  in  1  issue: mark iss_addr pending
iss_addr  in  AW  destination register of the issued instruction
pend_vec  out  NUM_REGS  scoreboard state, bit i = register i pending

Behaviour:
- Storage: NUM_REGS x XLEN flops; entry 0 is never written and always reads 0.
- Reset: reset_n=0 at a rising edge clears all registers and all pend_vec bits to 0. During that cycle, writes and issues are ignored. Afterwards, rd_data reads 0 for every address and rd_ready is all ones.
- Reset mid-operation: in-flight pending marks are discarded. There is no partial clear.
- Read (combinational, zero latency):
  - rd_data[k] = 0 if rd_addr[k]==0.
  - Otherwise, if BYPASS=1 and any wr_en[j] targets rd_addr[k], rd_data[k] = wr_data of the highest-index such j.
  - Otherwise, rd_data[k] = stored value.
- rd_ready[k] = ~pend_vec[rd_addr[k]]. With BYPASS=1, it is also 1 when a write to that address is present this cycle. Address 0 is always ready.
- Write: on a rising edge with reset_n=1, each wr_en[j] with wr_addr[j]!=0 stores wr_data[j].
- Write conflict: if two write ports target the same nonzero address in the same cycle, the higher-index port wins. This must be deterministic and is not an error.
- Scoreboard, per register i != 0, next-state precedence:
  - Reset: 0.
  - iss_en && iss_addr==i: 1. Set wins over a simultaneous clear, because the new producer supersedes the old one.
  - Any wr_en[j] && wr_addr[j]==i: 0.
  - Otherwise: hold.
- pend_vec[0] is constant 0. iss_en with iss_addr==0 has no effect.
- Issue to an already-pending register: stays 1. No counting and no error flag.
- Write to a non-pending register: is legal. The data is stored and the pend bit stays 0.
- No X propagation: with reset_n held low for one edge, all outputs are defined.

Decomposition:
- Shared package rv32i_pkg holds:
  - XLEN_DEFAULT=32 and REG_ADDR_W=5
  - REG_ZERO=5'd0
  - a function to slice packed port vectors
- One sub-module is natural: reg_bank_sb, the scoreboard (pend_vec register, set/clear precedence, rd_ready generation).
- reg_bank_mp instantiates reg_bank_sb alongside the storage array and bypass muxes.

Test Plan:
1. Reset: write x5=0xDEADBEEF, then reset_n=0 for one edge. Required: rd_addr=5 returns 0x00000000 and pend_vec==0.
2. x0: write 0x12345678 to address 0, and issue to address 0. Required: the read returns 0, pend_vec[0]=0 and rd_ready=1.
3. Bypass:
   - BYPASS=1: x7=0x11, then same-cycle wr x7=0x22 with read x7. Required: rd_data=0x22 that cycle and 0x22 the next cycle.
   - BYPASS=0: the same stimulus returns 0x11, then 0x22.
4. Write conflict: NUM_WRITE=2, port0 x9=0xAAAA and port1 x9=0xBBBB in the same cycle. Required: the next read of x9 returns 0xBBBB.
5. Scoreboard:
   - Issue x3. Required: pend_vec[3]=1 next cycle and rd_ready=0 for a port reading x3.
   - Write x3=0x5. Required: pend_vec[3]=0 and rd_ready=1.
   - Issue and write x3 in the same cycle. Required: pend_vec[3]=1.
6. Reset mid-operation: issue x10 and x11, write x12=0x77, then assert reset_n=0 in the same cycle as a write to x10. Required: all pend bits are 0, x10 reads 0 and x12 reads 0.
